// File: rtl/iter_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// iter_carry_skip_adder
//
// Sequential carry-skip adder/subtractor. One BLK-bit block is processed per
// clock, so an operation takes N_BLK = WIDTH/BLK cycles from accept to done.
// Inside each block a ripple chain produces the sum bits, while the block
// carry-out takes the skip path whenever every bit of the block propagates.
// The number of blocks that took the skip path is reported with each result.
//
// Parameters
//   WIDTH     operand/result width, must be a multiple of BLK
//   BLK       bits processed per cycle
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request a new operation (accepted in IDLE or DONE)
//   sub       0: A+B, 1: A-B (sampled with start)
//   A, B      operands (sampled with start)
//   busy      high while blocks are being processed
//   done      one-cycle pulse when S/C/V/skip_cnt are updated
//   S         result, held until the next completion
//   C         carry out of the MSB (for subtract: 1 = no borrow)
//   V         signed overflow
//   skip_cnt  blocks whose carry took the skip path in the last operation
//
// Optional feature
//   CSA_EARLY_EXIT_EN  when defined, the operation finishes as soon as the
//                      block carry-out is 0 and all remaining operand bits
//                      are 0; the upper result bits are then known to be 0.
// ---------------------------------------------------------------------------
module iter_carry_skip_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               sub,
  input  logic [WIDTH-1:0]                   A,
  input  logic [WIDTH-1:0]                   B,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH-1:0]                   S,
  output logic                               C,
  output logic                               V,
  output logic [$clog2(WIDTH/BLK+1)-1:0]     skip_cnt
);

  localparam int N_BLK = WIDTH / BLK;
  localparam int CNT_W = $clog2(N_BLK + 1);
  localparam int IDX_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand registers shift right by one block per cycle, so the block being
  // processed is always in the low BLK bits and the bits still to come are
  // everything above it.
  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic             carry_q,    carry_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [CNT_W-1:0] skip_q,     skip_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic [WIDTH-1:0] s_q,        s_d;
  logic             c_q,        c_d;
  logic             v_q,        v_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  // Current block datapath.
  logic [BLK-1:0]   blk_p;
  logic [BLK-1:0]   blk_g;
  logic [BLK:0]     rc;
  logic [BLK-1:0]   blk_sum;
  logic             blk_prop;
  logic             blk_cout;
  logic             last_blk;
  logic             early_exit;
  logic             finish;
  logic [WIDTH-1:0] sum_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    blk_p = a_q[BLK-1:0] ^ b_q[BLK-1:0];
    blk_g = a_q[BLK-1:0] & b_q[BLK-1:0];
    rc    = '0;
    rc[0] = carry_q;
    for (int i = 0; i < BLK; i++) begin
      rc[i+1] = blk_g[i] | (blk_p[i] & rc[i]);
    end
    blk_sum  = blk_p ^ rc[BLK-1:0];
    blk_prop = &blk_p;
    // Skip path: a fully propagating block passes its carry-in straight out.
    blk_cout = blk_prop ? carry_q : rc[BLK];
    last_blk = (idx_q == IDX_W'(N_BLK - 1));
    sum_nxt  = sum_q;
    sum_nxt[idx_q*BLK +: BLK] = blk_sum;
  end

`ifdef CSA_EARLY_EXIT_EN
  // Nothing left to add above this block and no carry heading into it:
  // the remaining result bits, C and V are all zero.
  assign early_exit = !blk_cout && ((a_q >> BLK) == '0) && ((b_q >> BLK) == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign finish = last_blk | early_exit;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    skip_d     = skip_q;
    sum_d      = sum_q;
    s_d        = s_q;
    c_d        = c_q;
    v_d        = v_q;
    skip_cnt_d = skip_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = A;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          b_d     = sub ? ~B : B;
          carry_d = sub;
          idx_d   = '0;
          skip_d  = '0;
          sum_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> BLK;
        b_d     = b_q >> BLK;
        carry_d = blk_cout;
        idx_d   = idx_q + IDX_W'(1);
        skip_d  = skip_q + CNT_W'(blk_prop);
        sum_d   = sum_nxt;
        if (finish) begin
          state_d    = ST_DONE;
          s_d        = sum_nxt;
          c_d        = blk_cout;
          // rc[BLK-1] is the carry into the MSB only when this is the top
          // block; an early exit guarantees no overflow.
          v_d        = last_blk ? (rc[BLK-1] ^ blk_cout) : 1'b0;
          skip_cnt_d = skip_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      skip_q     <= '0;
      sum_q      <= '0;
      s_q        <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      skip_q     <= skip_d;
      sum_q      <= sum_d;
      s_q        <= s_d;
      c_q        <= c_d;
      v_q        <= v_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign S        = s_q;
  assign C        = c_q;
  assign V        = v_q;
  assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_iter_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// tb_iter_carry_skip_adder
//
// Scoreboard bench for iter_carry_skip_adder (WIDTH=32, BLK=4). The driver
// pushes the expected result of every accepted operation into a queue; an
// independent monitor pops and compares whenever done is seen. Expected
// values come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_iter_carry_skip_adder;

  localparam int WIDTH = 32;
  localparam int BLK   = 4;
  localparam int N_BLK = WIDTH / BLK;
  localparam int CNT_W = $clog2(N_BLK + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic [CNT_W-1:0] skip_cnt;

  iter_carry_skip_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .C        (C),
    .V        (V),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    int               skip;
    int               lat;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: whole-word arithmetic, overflow from operand/result
  // signs, skip count from fully-propagating blocks.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] xr;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s);
    e.s    = full[WIDTH-1:0];
    e.c    = full[WIDTH];
    e.v    = (a[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != a[WIDTH-1]);
    e.lat  = N_BLK;
    e.acc  = 0;
`ifdef CSA_EARLY_EXIT_EN
    for (int k = 0; k < N_BLK - 1; k++) begin
      longint unsigned lo_a, lo_b, lo_sum;
      int              top;
      top    = (k + 1) * BLK;
      lo_a   = longint'(a) & ((64'd1 << top) - 64'd1);
      lo_b   = longint'(bb) & ((64'd1 << top) - 64'd1);
      lo_sum = lo_a + lo_b + longint'(s);
      if ((lo_sum >> top) == 0 && (a >> top) == 0 && (bb >> top) == 0) begin
        e.lat = k + 1;
        e.c   = 1'b0;
        e.v   = 1'b0;
        break;
      end
    end
`endif
    xr     = a ^ bb;
    e.skip = 0;
    for (int k = 0; k < e.lat; k++) begin
      if (xr[k*BLK +: BLK] == {BLK{1'b1}}) e.skip++;
    end
    return e;
  endfunction

  // Monitor: compares every completion against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("S",        64'(S),        64'(e.s));
        check("C",        64'(C),        64'(e.c));
        check("V",        64'(V),        64'(e.v));
        check("skip_cnt", 64'(skip_cnt), 64'(e.skip));
        check("latency",  64'(cyc - e.acc), 64'(e.lat));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Present an operation; returns on the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input bit hold);
    exp_t e;
    A     = a;
    B     = b;
    sub   = s;
    start = 1'b1;
    e     = model(a, b, s);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    n_vec++;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done (cycle %0d)",
               max_cyc, cyc);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_S"},        64'(S),        64'd0);
    check({tag, "_C"},        64'(C),        64'd0);
    check({tag, "_V"},        64'(V),        64'd0);
    check({tag, "_skip_cnt"}, 64'(skip_cnt), 64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_done"},     64'(done),     64'd0);
  endtask

  initial begin
    exp_t e1;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle");

    // Add with overflow; busy must cover exactly the processing cycles.
    e1 = model(32'hA0A0FFFF, 32'hA0BFFFE0, 1'b0);
    issue(32'hA0A0FFFF, 32'hA0BFFFE0, 1'b0, 1'b0);
    check("busy_first", 64'(busy), 64'd1);
    for (int i = 1; i < e1.lat; i++) begin
      @(negedge clk);
      check("busy_run", 64'(busy), 64'd1);
      check("done_early", 64'(done), 64'd0);
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);

    // Subtraction with and without borrow/overflow.
    issue(32'd5, 32'd7, 1'b1, 1'b0);
    wait_done(20);
    issue(32'h80000000, 32'd1, 1'b1, 1'b0);
    wait_done(20);

    // Skip statistics: seven fully propagating blocks.
    issue(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    wait_done(20);

    // Small operands (early-exit candidate).
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(20);

    // start mid-RUN must be ignored.
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    A     = 32'hDEADBEEF;
    B     = 32'h0BADF00D;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);

    // Reset during RUN discards the operation and clears the outputs.
    issue(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1 check_zero_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 64'(done), 64'd0);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done(20);

    // Back-to-back: start held high, new operands at each completion.
    issue(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1);
    wait_done(20);
    issue(32'hCAFEBABE, 32'h5A5A5A5A, 1'b1, 1'b1);
    wait_done(20);
    issue(32'h0000FFFF, 32'hFFFF0001, 1'b0, 1'b1);
    wait_done(20);
    start = 1'b0;
    @(negedge clk);

    // Randomised operations with a bias towards carry/skip corner cases.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
        2: begin ra = 32'hFFFFFFFF; rb = rb & 32'h0000000F; end
        default: rb = ~ra;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      wait_done(20);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
